// File: rtl/pe_block_fetcher.sv
// pe_block_fetcher: captures a block index from the control unit, reads that block from the
// shared memory bus into a local buffer, and holds it for the processing core until consumed.
module pe_block_fetcher #(
    parameter int index_width     = 8,
    parameter int greek_size      = 8,
    parameter int memory_size_log = 10,
    parameter int BLOCK_WORDS     = 16,
    parameter int BASE_ADDR       = 2
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset,
    input  logic                           i_Indexes_Ready,
    input  logic [index_width-1:0]         i_Row_Index,
    input  logic [index_width-1:0]         i_Column_Index,
    input  logic [greek_size-1:0]          i_Gamma,
    output logic                           o_Indexes_Received,
    output logic                           o_Grant_Request,
    input  logic                           i_Grant,
    output logic [memory_size_log-1:0]     o_Memory_Address,
    output logic                           o_Address_Valid,
    input  logic [31:0]                    i_Memory_Data,
    output logic                           o_Block_Valid,
    input  logic [$clog2(BLOCK_WORDS)-1:0] i_Block_Read_Addr,
    output logic [31:0]                    o_Block_Data,
    output logic [index_width-1:0]         o_Block_Row,
    output logic [index_width-1:0]         o_Block_Column,
    input  logic                           i_Block_Consumed,
    output logic                           o_Result_Ready
);
    localparam int WL = $clog2(BLOCK_WORDS);
    localparam int AW = memory_size_log;

    typedef enum logic [2:0] {IDLE, ACK, CALC, REQ, READ, VALID} state_t;

    state_t                 state_q, state_d;
    logic [index_width-1:0] row_q, row_d, col_q, col_d;
    logic [greek_size-1:0]  gamma_q, gamma_d;
    logic [AW-1:0]          base_q, base_d;
    logic [WL:0]            issued_q, issued_d;
    logic [WL-1:0]          word_q, word_d;
    logic                   pend_q, pend_d;
    logic                   ack_q, ack_d;
    logic                   req_q, req_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   issue, capture;
    logic [31:0]            buf_q [BLOCK_WORDS];

    // An address only goes out while the bus is ours; its data is taken the following cycle,
    // so a grant loss simply leaves the current address to be re-issued later.
    assign issue   = (state_q == READ) && i_Grant && !issued_q[WL];
    assign capture = (state_q == READ) && pend_q;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        gamma_d  = gamma_q;
        base_d   = base_q;
        issued_d = issued_q + (WL+1)'(issue);
        word_d   = word_q + WL'(capture);
        pend_d   = issue;
        ack_d    = 1'b0;
        req_d    = req_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (i_Indexes_Ready) begin
                row_d   = i_Row_Index;
                col_d   = i_Column_Index;
                gamma_d = i_Gamma;
                ack_d   = 1'b1;
                state_d = ACK;
            end
            ACK: state_d = CALC;
            CALC: begin
                base_d  = AW'(BASE_ADDR) + ((AW'(row_q) * AW'(gamma_q) + AW'(col_q)) << WL);
                req_d   = 1'b1;
                state_d = REQ;
            end
            REQ: if (i_Grant) begin
                issued_d = '0;
                word_d   = '0;
                pend_d   = 1'b0;
                state_d  = READ;
            end
            READ: if (capture && word_q == WL'(BLOCK_WORDS-1)) begin
                req_d   = 1'b0;
                valid_d = 1'b1;
                state_d = VALID;
            end
            VALID: if (i_Block_Consumed) begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            gamma_q  <= '0;
            base_q   <= '0;
            issued_q <= '0;
            word_q   <= '0;
            pend_q   <= 1'b0;
            ack_q    <= 1'b0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            gamma_q  <= gamma_d;
            base_q   <= base_d;
            issued_q <= issued_d;
            word_q   <= word_d;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (capture) buf_q[word_q] <= i_Memory_Data;
    end

    assign o_Indexes_Received = ack_q;
    assign o_Grant_Request    = req_q;
    assign o_Address_Valid    = issue;
    assign o_Memory_Address   = base_q + AW'(issued_q[WL-1:0]);
    assign o_Block_Valid      = valid_q;
    assign o_Block_Data       = valid_q ? buf_q[i_Block_Read_Addr] : '0;
    assign o_Block_Row        = row_q;
    assign o_Block_Column     = col_q;
    assign o_Result_Ready     = done_q;
endmodule

// File: tb/tb_pe_block_fetcher.sv
// tb_pe_block_fetcher: drives index handshakes, a one-cycle-latency memory and a grant pattern,
// and checks every cycle against a cycle-count/word-count model of the fetcher.
module tb_pe_block_fetcher;
    localparam int BW = 16;
    localparam int MS = 1024;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ready = 1'b0, grant = 1'b0, cons = 1'b0;
    logic [7:0]  row = '0, col = '0, gamma = '0;
    logic [31:0] mdata = '0, nxt = '0;
    logic [3:0]  raddr = '0;
    logic        ack, req, av, bv, rr;
    logic [9:0]  addr;
    logic [31:0] bdata;
    logic [7:0]  brow, bcol;
    logic [31:0] mem [MS];

    always #5 clk = ~clk;

    pe_block_fetcher dut (
        .i_Clock(clk), .i_Reset(rst_n), .i_Indexes_Ready(ready), .i_Row_Index(row),
        .i_Column_Index(col), .i_Gamma(gamma), .o_Indexes_Received(ack), .o_Grant_Request(req),
        .i_Grant(grant), .o_Memory_Address(addr), .o_Address_Valid(av), .i_Memory_Data(mdata),
        .o_Block_Valid(bv), .i_Block_Read_Addr(raddr), .o_Block_Data(bdata), .o_Block_Row(brow),
        .o_Block_Column(bcol), .i_Block_Consumed(cons), .o_Result_Ready(rr)
    );

    int checks = 0, passed = 0, cyc = 0, ca = 0;
    bit seen;
    bit m_busy, m_reading, m_valid, m_ack, m_rr, m_pend;
    int m_t, m_issued, m_recv, m_base;
    logic [7:0] m_row, m_col;
    int g_mode = 0, drop_left = 0, req_cyc = 0, cons_wait = 20, v_cnt = 0;
    bit p_go = 0, rnd = 0;
    logic [7:0] p_row, p_col, p_gamma;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        {m_busy, m_reading, m_valid, m_ack, m_rr, m_pend} = '0;
        m_t = 0; m_issued = 0; m_recv = 0; m_base = 0; m_row = '0; m_col = '0;
    endtask

    // Model of one rising edge, given the inputs that will be sampled there.
    task automatic model_step();
        m_ack = 0;
        m_rr  = 0;
        if (!m_busy) begin
            if (ready) begin
                m_busy = 1; m_t = 0; m_ack = 1; m_reading = 0; m_valid = 0;
                m_issued = 0; m_recv = 0; m_pend = 0; m_row = row; m_col = col;
                m_base = (2 + (int'(row) * int'(gamma) + int'(col)) * BW) % MS;
            end
        end else if (m_valid) begin
            if (cons) begin m_valid = 0; m_busy = 0; m_rr = 1; end
        end else if (m_reading) begin
            m_recv  += int'(m_pend);
            m_pend   = grant && m_issued < BW;
            m_issued += int'(m_pend);
            if (m_recv == BW) begin m_valid = 1; m_reading = 0; end
        end else begin
            m_t++;
            if (m_t >= 3 && grant) m_reading = 1;
        end
    endtask

    always @(posedge clk) mdata <= nxt;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            model_reset();
            chk("reset_outputs", {ack, req, av, bv, rr, addr, bdata, brow, bcol}, 0);
        end
        chk("ack", ack, m_ack);
        chk("grant_request", req, m_busy && !m_valid && m_t >= 2);
        chk("addr_valid", av, m_reading && grant && m_issued < BW);
        if (av) chk("address", addr, (m_base + m_issued) % MS);
        chk("block_valid", bv, m_valid);
        chk("result_ready", rr, m_rr);
        if (m_valid) begin
            chk("block_row", brow, m_row);
            chk("block_col", bcol, m_col);
            chk("block_data", bdata, mem[(m_base + int'(raddr)) % MS]);
        end
        if (ack) begin ready = 0; p_go = 0; end
        else if (p_go && !ready) begin ready = 1; row = p_row; col = p_col; gamma = p_gamma; end
        req_cyc = req ? req_cyc + 1 : 0;
        if (g_mode == 0) grant = 1;
        else if (g_mode == 1) grant = ($urandom_range(0, 3) != 0);
        else if (req_cyc < 6) grant = 0;
        else if (m_reading && m_issued == 7 && drop_left > 0) begin grant = 0; drop_left--; end
        else grant = 1;
        cons = 0;
        if (bv) begin
            v_cnt++;
            if (v_cnt > cons_wait) begin
                cons = 1;
                if (rnd) cons_wait = $urandom_range(0, 20);
            end
        end else v_cnt = 0;
        raddr = rnd ? 4'($urandom_range(0, 15)) : raddr + 4'd1;
        #1;
        nxt = av ? mem[addr] : $urandom();
        if (rst_n) model_step();
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_ack(input int lim);
        for (int i = 0; i < lim && p_go; i++) tick();
        chk("ack_wait", p_go, 0);
    endtask

    task automatic wait_bv(input int lim);
        for (int i = 0; i < lim && !bv; i++) tick();
        chk("block_valid_wait", bv, 1);
    endtask

    task automatic wait_rr(input int lim);
        for (int i = 0; i < lim && !rr; i++) tick();
        chk("result_ready_wait", rr, 1);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < MS; i++) mem[i] = $urandom();
        p_row = 8'd1; p_col = 8'd2; p_gamma = 8'd3; p_go = 1;
        repeat (4) tick();
        chk("no_ack_in_reset", ack, 0);
        @(posedge clk); #2 rst_n = 1;
        wait_ack(10);
        ca = cyc;
        chk("base_pin", m_base, 82);
        tick();
        chk("ack_pulse", ack, 0);
        seen = 0;
        for (int i = 0; i < 40 && !bv; i++) begin
            if (av && !seen) begin seen = 1; chk("first_addr", addr, 82); end
            tick();
        end
        chk("block_valid_wait", bv, 1);
        chk("latency", cyc - ca, 20);
        wait_rr(60);
        // delayed grant, then two lost-grant cycles while word 7 is due
        g_mode = 2; drop_left = 2; p_go = 1;
        wait_ack(20);
        seen = 0;
        for (int i = 0; i < 100 && !bv; i++) begin
            if (drop_left == 0 && av && !seen) begin seen = 1; chk("resume_addr", addr, 89); end
            tick();
        end
        chk("block_valid_wait", bv, 1);
        chk("resume_seen", seen, 1);
        wait_rr(60);
        g_mode = 0; p_row = 8'd255; p_col = 8'd0; p_gamma = 8'd255; p_go = 1;
        wait_ack(20);
        chk("wrap_pin", m_base, 18);
        seen = 0;
        for (int i = 0; i < 40 && !bv; i++) begin
            if (av && !seen) begin seen = 1; chk("wrap_first_addr", addr, 18); end
            tick();
        end
        wait_rr(60);
        // next index held high through READ and VALID, coinciding with the consume
        p_row = 8'd7; p_col = 8'd9; p_gamma = 8'd4; cons_wait = 2; p_go = 1;
        wait_ack(20);
        p_row = 8'd9; p_col = 8'd4; p_gamma = 8'd6; p_go = 1;
        wait_rr(60);
        tick();
        chk("ack_after_consume", ack, 1);
        wait_bv(60);
        chk("held_row", brow, 9);
        chk("held_col", bcol, 4);
        wait_rr(60);
        p_row = 8'd3; p_col = 8'd3; p_gamma = 8'd2; p_go = 1;
        wait_ack(20);
        for (int i = 0; i < 40 && !av; i++) tick();
        chk("reading_before_reset", av, 1);
        @(negedge clk);
        #3 rst_n = 0;
        #1 chk("async_reset_outputs", {ack, req, av, bv, rr}, 0);
        repeat (3) tick();
        @(posedge clk); #2 rst_n = 1;
        g_mode = 1; rnd = 1;
        for (int n = 0; n < 30; n++) begin
            p_row = 8'($urandom()); p_col = 8'($urandom()); p_gamma = 8'($urandom());
            p_go = 1;
            wait_ack(300);
        end
        repeat (120) tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
